// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Definitions shared by the pipeline control blocks: the hazard controller and
// the EX-stage forwarding unit.
//   REG_W       : width of a register-number field (rs/rt/rd)
//   hz_state_e  : hazard controller state encoding (RUN / MEM_WAIT)
//   hz_ctrl_t   : bundle of pipeline-register enables and flushes
//   CTRL_*      : the five control patterns the hazard controller can drive
//   is_load_use : detects a load in EX whose destination is read by ID
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic memwb_flush;
  } hz_ctrl_t;

  // Free-running pipeline: every stage advances, nothing is cleared.
  localparam hz_ctrl_t CTRL_NORMAL = '{
    pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
    idex_write: 1'b1, idex_flush: 1'b0, exmem_write: 1'b1, memwb_flush: 1'b0};

  // Data memory busy: everything up to EX/MEM holds, WB receives a nop so the
  // stalled MEM instruction is not retired twice.
  localparam hz_ctrl_t CTRL_FREEZE = '{
    pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
    idex_write: 1'b0, idex_flush: 1'b0, exmem_write: 1'b0, memwb_flush: 1'b1};

  // Taken branch / jump: load the target, squash the two wrong-path slots.
  localparam hz_ctrl_t CTRL_REDIRECT = '{
    pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
    idex_write: 1'b1, idex_flush: 1'b1, exmem_write: 1'b1, memwb_flush: 1'b0};

  // Load-use: hold PC and IF/ID, insert one bubble into ID/EX, let the load move on.
  localparam hz_ctrl_t CTRL_BUBBLE = '{
    pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
    idex_write: 1'b1, idex_flush: 1'b1, exmem_write: 1'b1, memwb_flush: 1'b0};

  // Held in reset: nothing is written and every stage boundary carries a nop.
  localparam hz_ctrl_t CTRL_RESET = '{
    pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
    idex_write: 1'b0, idex_flush: 1'b1, exmem_write: 1'b0, memwb_flush: 1'b1};

  // $0 is hard-wired to zero, so a load "into" it can never feed a consumer.
  function automatic logic is_load_use(
    input logic             ex_memread,
    input logic [REG_W-1:0] ex_rt,
    input logic [REG_W-1:0] id_rs,
    input logic [REG_W-1:0] id_rt,
    input logic             id_uses_rt
  );
    return ex_memread && (ex_rt != '0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   rst   : synchronous active-high clear
//   inc   : add one this cycle (ignored once saturated)
//   count : current value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Stall/flush controller for the 5-stage MIPS pipeline. Handles the hazards
// that forwarding cannot: load-use (one bubble), taken branch/jump (flush
// IF/ID and ID/EX) and multi-cycle data-memory accesses (freeze).
//
// Inputs : clk, rst, ifid_rs/ifid_rt/ifid_uses_rt (ID sources),
//          idex_memread/idex_rt (load in EX), ex_redirect (EX redirect),
//          dmem_req/dmem_ready (MEM-stage memory handshake)
// Outputs: pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
//          exmem_write, memwb_flush (pipeline register controls),
//          mem_err (sticky timeout), stall_cycles, flush_count (saturating)
//
// Controls are combinational from state and inputs; state, the wait counter,
// the error flag and the performance counters are registered.
// -----------------------------------------------------------------------------
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hz_state_e         state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              mem_err_reg, mem_err_next;

  hz_ctrl_t ctrl;
  logic     load_use;
  logic     mem_stall;
  logic     frozen;
  logic     redirect_taken;

  always_comb begin
    ctrl           = CTRL_NORMAL;
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    mem_err_next   = mem_err_reg;
    redirect_taken = 1'b0;

    load_use  = is_load_use(idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt);
    mem_stall = dmem_req && !dmem_ready;

    // Once waiting, only dmem_ready matters: the MEM instruction is held in
    // place, so its request is still outstanding by construction.
    frozen = (state_reg == MEM_WAIT) ? !dmem_ready : mem_stall;

    if (frozen) begin
      ctrl       = CTRL_FREEZE;
      state_next = MEM_WAIT;
      if (state_reg == RUN) begin
        wait_cnt_next = WAIT_W'(1);
      end else if (wait_cnt_reg < WAIT_MAX) begin
        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
      end
      if (wait_cnt_next == WAIT_MAX) begin
        mem_err_next = 1'b1;
      end
    end else begin
      // Normal RUN decision; in the MEM_WAIT release cycle this resolves any
      // redirect or load-use that was frozen in EX/ID during the wait.
      state_next    = RUN;
      wait_cnt_next = '0;
      if (ex_redirect) begin
        // ID holds a wrong-path instruction, so its load-use is irrelevant.
        ctrl           = CTRL_REDIRECT;
        redirect_taken = 1'b1;
      end else if (load_use) begin
        ctrl = CTRL_BUBBLE;
      end
    end

    if (rst) begin
      ctrl = CTRL_RESET;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err_reg  <= mem_err_next;
    end
  end

  // Counter 0: cycles with the PC held. Counter 1: redirect flushes.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc[0] = !rst && !ctrl.pc_write;
  assign cnt_inc[1] = !rst && redirect_taken;

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
    sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cnt_inc[gi]),
      .count (cnt_val[gi])
    );
  end

  assign pc_write     = ctrl.pc_write;
  assign ifid_write   = ctrl.ifid_write;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_write   = ctrl.idex_write;
  assign idex_flush   = ctrl.idex_flush;
  assign exmem_write  = ctrl.exmem_write;
  assign memwb_flush  = ctrl.memwb_flush;
  assign mem_err      = mem_err_reg;
  assign stall_cycles = cnt_val[0];
  assign flush_count  = cnt_val[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Drives hazard_ctrl with directed and random cycles. The stimulus process
// computes each cycle's expected response from a behavioural model and
// pushes it to a scoreboard queue; the monitor pops and compares on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int T_OUT   = 4;
  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  // Control vector order:
  // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_flush}
  localparam logic [6:0] V_RESET  = 7'b0010101;
  localparam logic [6:0] V_NORMAL = 7'b1101010;
  localparam logic [6:0] V_FREEZE = 7'b0000001;
  localparam logic [6:0] V_REDIR  = 7'b1111110;
  localparam logic [6:0] V_BUBBLE = 7'b0001110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
  logic       ifid_uses_rt = 1'b0, idex_memread = 1'b0, ex_redirect = 1'b0;
  logic       dmem_req = 1'b0, dmem_ready = 1'b0;
  logic       pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic       exmem_write, memwb_flush, mem_err;
  logic [CW-1:0] stall_cycles, flush_count;

  hazard_ctrl #(
    .MEM_TIMEOUT (T_OUT),
    .CNT_W       (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ex_redirect  (ex_redirect),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_write   (idex_write),
    .idex_flush   (idex_flush),
    .exmem_write  (exmem_write),
    .memwb_flush  (memwb_flush),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [6:0] ctrl;
    logic       err;
    int         stall;
    int         flush;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  // Behavioural model: "waiting" means a memory access is outstanding.
  bit m_waiting = 0;
  int m_wait_len = 0;
  bit m_err = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic cyc(input bit r, input int rs, input int rt, input bit urt,
                     input bit mr, input int lrt, input bit redir,
                     input bit req, input bit rdy);
    exp_t e;
    bit   lu;
    bit   busy;
    @(posedge clk);
    #1;
    rst          = r;
    ifid_rs      = 5'(rs);
    ifid_rt      = 5'(rt);
    ifid_uses_rt = urt;
    idex_memread = mr;
    idex_rt      = 5'(lrt);
    ex_redirect  = redir;
    dmem_req     = req;
    dmem_ready   = rdy;

    e.idx   = n_txn;
    e.err   = m_err;
    e.stall = m_stall;
    e.flush = m_flush;
    n_txn++;

    if (r) begin
      e.ctrl     = V_RESET;
      m_waiting  = 0;
      m_wait_len = 0;
      m_err      = 0;
      m_stall    = 0;
      m_flush    = 0;
    end else begin
      lu   = mr && (lrt != 0) && (lrt == rs || (urt && lrt == rt));
      busy = m_waiting ? !rdy : (req && !rdy);
      if (busy)       e.ctrl = V_FREEZE;
      else if (redir) e.ctrl = V_REDIR;
      else if (lu)    e.ctrl = V_BUBBLE;
      else            e.ctrl = V_NORMAL;

      if (busy) begin
        m_waiting  = 1;
        m_wait_len = (m_wait_len < T_OUT) ? m_wait_len + 1 : T_OUT;
        if (m_wait_len >= T_OUT) m_err = 1;
      end else begin
        m_waiting  = 0;
        m_wait_len = 0;
      end
      if (!e.ctrl[6] && m_stall < CNT_MAX) m_stall++;
      if (e.ctrl == V_REDIR && m_flush < CNT_MAX) m_flush++;
    end
    sb_q.push_back(e);
  endtask

  // Monitor: compares one scoreboard entry per cycle, on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      bit ok;
      e   = sb_q.pop_front();
      act = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_flush};
      ok  = 1;
      n_checks++;
      if (act !== e.ctrl) begin
        n_fail++; ok = 0;
        $display("FAIL txn %0d ctrl: got %b expected %b", e.idx, act, e.ctrl);
      end
      n_checks++;
      if (mem_err !== e.err) begin
        n_fail++; ok = 0;
        $display("FAIL txn %0d mem_err: got %b expected %b", e.idx, mem_err, e.err);
      end
      n_checks++;
      if (stall_cycles !== CW'(e.stall) || flush_count !== CW'(e.flush)) begin
        n_fail++; ok = 0;
        $display("FAIL txn %0d counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.idx, stall_cycles, flush_count, e.stall, e.flush);
      end
      if (ok)
        $display("txn %0d ctrl=%b err=%b stall=%0d flush=%0d ok",
                 e.idx, act, mem_err, stall_cycles, flush_count);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rs, rt, lrt;
    bit slow;
    // Reset
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // lw $2 in EX; add $3,$2,$4 in ID -> one bubble, then release
    cyc(0, 2, 4, 1, 1, 2, 0, 0, 0);
    cyc(0, 2, 4, 1, 0, 0, 0, 0, 0);
    // lw $0 with ID reading $0: no stall
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // lw $5; addi reads rs=$6 only (rt=$5 not a source): no stall
    cyc(0, 6, 5, 0, 1, 5, 0, 0, 0);
    // Redirect coincident with load-use: redirect wins
    cyc(0, 2, 4, 1, 1, 2, 1, 0, 0);
    // Memory wait of 3 cycles with a redirect held in EX, then release
    cyc(0, 1, 1, 1, 0, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 0, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 0, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 0, 0, 1, 1, 1);
    cyc(0, 1, 1, 1, 0, 0, 0, 0, 0);
    // Timeout: ready never comes, mem_err rises and sticks; reset clears it
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Random traffic, alternating fast and slow memory phases
    for (int i = 0; i < 500; i++) begin
      slow = ((i / 50) % 3) == 2;
      rs   = $urandom_range(0, 3);
      rt   = $urandom_range(0, 3);
      lrt  = $urandom_range(0, 3);
      cyc(($urandom_range(0, 199) == 0),
          rs, rt, $urandom_range(0, 1), ($urandom_range(0, 9) < 4), lrt,
          ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 3),
          slow ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 6));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
